// File: rtl/life_engine_if.sv
// Logic-side bus between life_engine and the double buffer: start/ready control,
// fixed-latency read port, write port and generation status.
interface life_engine_if #(
    parameter int WORD_SIZE    = 32,
    parameter int LOG_MAX_ADDR = 12
);
    logic                    start_in;
    logic                    buf_ready_in;
    logic [WORD_SIZE-1:0]    logic_data_r;
    logic [LOG_MAX_ADDR-1:0] logic_addr_r;
    logic [LOG_MAX_ADDR-1:0] logic_addr_w;
    logic [WORD_SIZE-1:0]    logic_data_w;
    logic                    logic_wr_en;
    logic                    swap_out;
    logic                    busy_out;
    logic [15:0]             gen_count_out;

    modport master (
        input  start_in, buf_ready_in, logic_data_r,
        output logic_addr_r, logic_addr_w, logic_data_w, logic_wr_en,
               swap_out, busy_out, gen_count_out
    );

    modport slave (
        output start_in, buf_ready_in, logic_data_r,
        input  logic_addr_r, logic_addr_w, logic_data_w, logic_wr_en,
               swap_out, busy_out, gen_count_out
    );
endinterface

// File: rtl/life_engine.sv
// Conway B3/S23 generation engine: reads the board word by word, writes the next generation, pulses swap_out.
// Latency READ_LATENCY+4 cycles per word plus READ_LATENCY+3 per row prime (doubled with LIFE_WRAP_EN: torus board).
// Backpressure: start_in taken only in IDLE with buf_ready_in high; fixed-latency reads, no stalls.
module life_engine #(
    parameter int WORDS_PER_ROW = 10,
    parameter int ROWS          = 240,
    parameter int READ_LATENCY  = 2,
    parameter int WORD_SIZE     = 32,
    parameter int LOG_MAX_ADDR  = 12
) (
    input  logic          clk_in,
    input  logic          rst_in,
    life_engine_if.master bus
);
`ifdef LIFE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam int RL    = READ_LATENCY;
    localparam int COL_W = $clog2(WORDS_PER_ROW + 1);
    localparam int ROW_W = $clog2(ROWS + 1);
    localparam logic [1:0] DST_L = 2'd0, DST_C = 2'd1, DST_R = 2'd2;
    localparam logic [COL_W-1:0] PRIME_COL = WRAP ? COL_W'(WORDS_PER_ROW - 1) : '0;
    localparam logic [1:0]       PRIME_DST = WRAP ? DST_L : DST_C;

    typedef enum logic [2:0] {IDLE, PRIME, FETCH, WAIT, WRITE, SWAP} state_t;
    typedef logic [2:0][WORD_SIZE-1:0] col_t;   // [0]=up, [1]=mid, [2]=down

    state_t                state;
    col_t                  win_l, win_c, win_r, r_nxt;
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      col, seq_col;
    logic [1:0]            seq_dst, iss_cnt;
    logic [RL:0]           tag_vld, tag_zero, tag_last;
    logic [RL:0][1:0]      tag_slot, tag_dst;

    logic                    iss_go, iss_zero, cap_vld, cap_last;
    logic [1:0]              iss_slot, iss_dst;
    logic [COL_W-1:0]        iss_col;
    logic [ROW_W-1:0]        iss_row;
    logic [LOG_MAX_ADDR-1:0] iss_addr;
    logic [WORD_SIZE-1:0]    cap_dat;

    function automatic logic [WORD_SIZE-1:0] life_next(input col_t l, input col_t c, input col_t r);
        logic [2:0][WORD_SIZE+1:0] ext;
        logic [3:0]                n;
        logic [WORD_SIZE-1:0]      nxt;
        for (int k = 0; k < 3; k++) ext[k] = {r[k][0], c[k], l[k][WORD_SIZE-1]};
        nxt = '0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            n = {3'b0, ext[0][i]} + {3'b0, ext[0][i+1]} + {3'b0, ext[0][i+2]}
              + {3'b0, ext[1][i]} + {3'b0, ext[1][i+2]}
              + {3'b0, ext[2][i]} + {3'b0, ext[2][i+1]} + {3'b0, ext[2][i+2]};
            nxt[i] = (n == 4'd3) | (ext[1][i+1] & (n == 4'd2));
        end
        return nxt;
    endfunction

    assign cap_vld  = tag_vld[RL];
    assign cap_last = cap_vld & tag_last[RL];
    assign cap_dat  = tag_zero[RL] ? '0 : bus.logic_data_r;

    // Each read is issued on the edge entering its fetch cycle, so the address is live during that cycle.
    always_comb begin
        iss_go   = 1'b0;
        iss_slot = iss_cnt;
        iss_col  = seq_col;
        iss_row  = row;
        iss_dst  = seq_dst;
        case (state)
            IDLE: if (bus.start_in && bus.buf_ready_in) begin
                iss_go = 1'b1; iss_slot = 2'd0; iss_row = '0;
                iss_col = PRIME_COL; iss_dst = PRIME_DST;
            end
            PRIME: if (iss_cnt != 2'd3) begin
                iss_go = 1'b1;
            end else if (cap_last) begin
                iss_go = 1'b1; iss_slot = 2'd0;
                if (tag_dst[RL] == DST_L) begin
                    iss_col = '0; iss_dst = DST_C;
                end else begin
                    iss_col = COL_W'(1); iss_dst = DST_R;
                end
            end
            FETCH: iss_go = (iss_cnt != 2'd3);
            WRITE: if (int'(col) != WORDS_PER_ROW - 1) begin
                iss_go = 1'b1; iss_slot = 2'd0; iss_col = col + COL_W'(2); iss_dst = DST_R;
            end else if (int'(row) != ROWS - 1) begin
                iss_go = 1'b1; iss_slot = 2'd0; iss_row = row + ROW_W'(1);
                iss_col = PRIME_COL; iss_dst = PRIME_DST;
            end
            default: ;
        endcase
    end

    always_comb begin
        int r, c;
        r = int'(iss_row) + int'(iss_slot) - 1;
        c = int'(iss_col);
        iss_zero = 1'b0;
        if (r < 0) begin
            r = ROWS - 1; iss_zero = !WRAP;
        end else if (r >= ROWS) begin
            r = 0; iss_zero = !WRAP;
        end
        if (c >= WORDS_PER_ROW) begin
            c = 0; iss_zero = iss_zero | !WRAP;
        end
        iss_addr = LOG_MAX_ADDR'(r * WORDS_PER_ROW + c);
    end

    always_comb begin
        r_nxt = win_r;
        if (cap_vld && tag_dst[RL] == DST_R) r_nxt[tag_slot[RL]] = cap_dat;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            row <= '0; col <= '0; seq_col <= '0; seq_dst <= '0; iss_cnt <= '0;
            tag_vld <= '0; tag_zero <= '0; tag_last <= '0; tag_slot <= '0; tag_dst <= '0;
            win_l <= '0; win_c <= '0; win_r <= '0;
            bus.logic_addr_r <= '0; bus.logic_addr_w <= '0; bus.logic_data_w <= '0;
            bus.logic_wr_en <= 1'b0; bus.swap_out <= 1'b0; bus.busy_out <= 1'b0;
            bus.gen_count_out <= '0;
        end else begin
            tag_vld[0]  <= iss_go;
            tag_zero[0] <= iss_zero;
            tag_last[0] <= (iss_slot == 2'd2);
            tag_slot[0] <= iss_slot;
            tag_dst[0]  <= iss_dst;
            for (int k = 1; k <= RL; k++) begin
                tag_vld[k] <= tag_vld[k-1]; tag_zero[k] <= tag_zero[k-1];
                tag_last[k] <= tag_last[k-1]; tag_slot[k] <= tag_slot[k-1]; tag_dst[k] <= tag_dst[k-1];
            end
            if (iss_go) begin
                if (!iss_zero) bus.logic_addr_r <= iss_addr;
                seq_col <= iss_col;
                seq_dst <= iss_dst;
                iss_cnt <= iss_slot + 2'd1;
            end
            if (cap_vld) begin
                case (tag_dst[RL])
                    DST_L:   win_l[tag_slot[RL]] <= cap_dat;
                    DST_C:   win_c[tag_slot[RL]] <= cap_dat;
                    default: win_r <= r_nxt;
                endcase
            end
            case (state)
                IDLE: if (bus.start_in && bus.buf_ready_in) begin
                    state <= PRIME; bus.busy_out <= 1'b1;
                    row <= '0; col <= '0; win_l <= '0;
                end
                PRIME: if (cap_last && tag_dst[RL] == DST_C) state <= FETCH;
                FETCH: if (iss_cnt == 2'd3) state <= WAIT;
                WAIT: if (cap_last) begin
                    state <= WRITE;
                    bus.logic_wr_en  <= 1'b1;
                    bus.logic_addr_w <= LOG_MAX_ADDR'(int'(row) * WORDS_PER_ROW + int'(col));
                    bus.logic_data_w <= life_next(win_l, win_c, r_nxt);
                end
                WRITE: begin
                    bus.logic_wr_en <= 1'b0;
                    win_l <= win_c;
                    win_c <= win_r;
                    if (int'(col) == WORDS_PER_ROW - 1) begin
                        col <= '0;
                        if (int'(row) == ROWS - 1) begin
                            state <= SWAP; bus.swap_out <= 1'b1;
                            bus.gen_count_out <= bus.gen_count_out + 16'd1;
                        end else begin
                            state <= PRIME; row <= row + ROW_W'(1); win_l <= '0;
                        end
                    end else begin
                        state <= FETCH; col <= col + COL_W'(1);
                    end
                end
                SWAP: begin
                    state <= IDLE; bus.swap_out <= 1'b0; bus.busy_out <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: double-buffer memory model with fixed read latency and a cell-level
// reference model of the Game of Life; compile with LIFE_WRAP_EN to exercise the torus build.
module tb_life_engine;
    localparam int WPR = 4, ROWS = 32, RL = 2, WS = 32, LMA = 12;
    localparam int NW = WPR * ROWS, NCOL = WPR * WS;
`ifdef LIFE_WRAP_EN
    localparam int PRIME_CYC = 2 * (RL + 3);
    localparam bit WRAP = 1'b1;
`else
    localparam int PRIME_CYC = RL + 3;
    localparam bit WRAP = 1'b0;
`endif
    localparam int GEN_CYC = ROWS * (PRIME_CYC + WPR * (RL + 4)) + 1;

    typedef bit board_t [ROWS][NCOL];

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    life_engine_if #(.WORD_SIZE(WS), .LOG_MAX_ADDR(LMA)) bus ();

    life_engine #(
        .WORDS_PER_ROW(WPR), .ROWS(ROWS), .READ_LATENCY(RL),
        .WORD_SIZE(WS), .LOG_MAX_ADDR(LMA)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus(bus)
    );

    logic [WS-1:0] mem_rd [NW];
    logic [WS-1:0] wr_mem [NW];
    logic [WS-1:0] rd_pipe [RL];
    int wr_cnt = 0, swap_cnt = 0, addr_err = 0;
    int n_chk = 0, n_bad = 0, gens = 0;
    board_t mdl;

    always @(posedge clk_in) begin
        rd_pipe[0] <= (int'(bus.logic_addr_r) < NW) ? mem_rd[bus.logic_addr_r] : '0;
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bus.logic_data_r = rd_pipe[RL-1];

    always @(negedge clk_in) begin
        if (bus.logic_wr_en) begin
            if (int'(bus.logic_addr_w) < NW) wr_mem[bus.logic_addr_w] <= bus.logic_data_w;
            if (int'(bus.logic_addr_w) != wr_cnt % NW) addr_err <= addr_err + 1;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.swap_out) swap_cnt <= swap_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic clear_board();
        for (int r = 0; r < ROWS; r++)
            for (int x = 0; x < NCOL; x++) mdl[r][x] = 1'b0;
    endtask

    function automatic logic [WS-1:0] mdl_word(input int a);
        logic [WS-1:0] w;
        for (int b = 0; b < WS; b++) w[b] = mdl[a / WPR][(a % WPR) * WS + b];
        return w;
    endfunction

    function automatic logic [WS-1:0] word_at(input int r, input int c);
        return mem_rd[r * WPR + c];
    endfunction

    task automatic load_board();
        for (int a = 0; a < NW; a++) mem_rd[a] = mdl_word(a);
    endtask

    // Reference: count the eight neighbours of every cell directly on the cell grid.
    task automatic model_step();
        board_t nx;
        for (int r = 0; r < ROWS; r++) begin
            for (int x = 0; x < NCOL; x++) begin
                int n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int rr = r + dy;
                        int xx = x + dx;
                        if (dy == 0 && dx == 0) continue;
                        if (WRAP) begin
                            rr = (rr + ROWS) % ROWS;
                            xx = (xx + NCOL) % NCOL;
                        end else if (rr < 0 || rr >= ROWS || xx < 0 || xx >= NCOL) begin
                            continue;
                        end
                        n += int'(mdl[rr][xx]);
                    end
                end
                nx[r][x] = (n == 3) || (mdl[r][x] && n == 2);
            end
        end
        mdl = nx;
    endtask

    task automatic compare_board(input string tag);
        int bad_words = 0;
        for (int a = 0; a < NW; a++) if (mem_rd[a] !== mdl_word(a)) bad_words++;
        check(tag, bad_words, 0);
    endtask

    task automatic run_gen(input string tag, input bit extra_start);
        int cyc, w0, s0;
        w0 = wr_cnt;
        s0 = swap_cnt;
        bus.buf_ready_in = 1'b1;
        bus.start_in = 1'b1;
        tick(1);
        bus.start_in = 1'b0;
        cyc = 1;
        check({tag, "_busy_rise"}, bus.busy_out, 1);
        while (!bus.swap_out && cyc < GEN_CYC + 100) begin
            bus.start_in = extra_start && (cyc == 300);
            tick(1);
            cyc++;
        end
        bus.start_in = 1'b0;
        check({tag, "_gen_cycles"}, cyc, GEN_CYC);
        gens++;
        check({tag, "_gen_count"}, bus.gen_count_out, gens);
        tick(1);
        check({tag, "_busy_fall"}, {bus.busy_out, bus.swap_out}, 0);
        check({tag, "_writes"}, wr_cnt - w0, NW);
        check({tag, "_swaps"}, swap_cnt - s0, 1);
        check({tag, "_wr_order"}, addr_err, 0);
        for (int a = 0; a < NW; a++) mem_rd[a] = wr_mem[a];
        model_step();
        compare_board({tag, "_board"});
    endtask

    initial begin
        int w0, s0;
        rst_in = 1'b1;
        bus.start_in = 1'b0;
        bus.buf_ready_in = 1'b1;
        clear_board();
        load_board();
        tick(3);
        check("rst_busy", bus.busy_out, 0);
        check("rst_swap", bus.swap_out, 0);
        check("rst_wr_en", bus.logic_wr_en, 0);
        check("rst_gen_count", bus.gen_count_out, 0);
        check("rst_addr", {bus.logic_addr_r, bus.logic_addr_w}, 0);
        check("rst_data_w", bus.logic_data_w, 0);
        rst_in = 1'b0;
        tick(2);

        // Blinker, with a start pulse while busy that must be ignored.
        clear_board();
        for (int b = 3; b <= 5; b++) mdl[5][2 * WS + b] = 1'b1;
        load_board();
        run_gen("blinker", 1'b1);
        check("blinker_r4", word_at(4, 2), 32'h10);
        check("blinker_r5", word_at(5, 2), 32'h10);
        check("blinker_r6", word_at(6, 2), 32'h10);
        w0 = wr_cnt;
        tick(60);
        check("busy_start_ignored", {bus.busy_out, 32'(wr_cnt - w0)}, 0);

        // Start while the buffer is not ready is dropped.
        bus.buf_ready_in = 1'b0;
        bus.start_in = 1'b1;
        tick(1);
        bus.start_in = 1'b0;
        bus.buf_ready_in = 1'b1;
        tick(40);
        check("notready_dropped", {bus.busy_out, 32'(wr_cnt - w0)}, 0);

        // Block straddling the word 0 / word 1 boundary is a still life.
        clear_board();
        for (int r = 10; r <= 11; r++) begin
            mdl[r][31] = 1'b1;
            mdl[r][32] = 1'b1;
        end
        load_board();
        for (int g = 0; g < 3; g++) run_gen("block", 1'b0);
        for (int r = 10; r <= 11; r++) begin
            check("block_w0", word_at(r, 0), 32'h8000_0000);
            check("block_w1", word_at(r, 1), 32'h1);
        end

        // Glider moving right/down across the word boundary.
        clear_board();
        mdl[2][29] = 1'b1; mdl[3][30] = 1'b1;
        mdl[4][28] = 1'b1; mdl[4][29] = 1'b1; mdl[4][30] = 1'b1;
        load_board();
        for (int g = 0; g < 8; g++) run_gen("glider", 1'b0);
        check("glider_r4w0", word_at(4, 0), 32'h8000_0000);
        check("glider_r5w1", word_at(5, 1), 32'h1);
        check("glider_r6w0", word_at(6, 0), 32'hC000_0000);
        check("glider_r6w1", word_at(6, 1), 32'h1);

        // Random soup against the reference model.
        for (int r = 0; r < ROWS; r++)
            for (int x = 0; x < NCOL; x++) mdl[r][x] = ($urandom_range(0, 3) == 0);
        load_board();
        run_gen("soup1", 1'b0);
        run_gen("soup2", 1'b0);

        // Blinker on the top edge.
        clear_board();
        for (int b = 0; b <= 2; b++) mdl[0][b] = 1'b1;
        load_board();
        run_gen("edge", 1'b0);
        check("edge_r0", word_at(0, 0), 32'h2);
        check("edge_r1", word_at(1, 0), 32'h2);
        check("edge_rlast", word_at(ROWS - 1, 0), WRAP ? 32'h2 : 32'h0);
        check("edge_r0_lastcol", word_at(0, WPR - 1), 32'h0);

        // Reset in the middle of a generation.
        w0 = wr_cnt;
        s0 = swap_cnt;
        bus.start_in = 1'b1;
        tick(1);
        bus.start_in = 1'b0;
        for (int c = 0; c < GEN_CYC && wr_cnt - w0 < 100; c++) tick(1);
        check("reach_100_writes", wr_cnt - w0 >= 100, 1);
        rst_in = 1'b1;
        tick(1);
        rst_in = 1'b0;
        check("midrst_busy", bus.busy_out, 0);
        check("midrst_gen_count", bus.gen_count_out, 0);
        w0 = wr_cnt;
        tick(GEN_CYC + 50);
        check("midrst_no_writes", wr_cnt - w0, 0);
        check("midrst_no_swap", swap_cnt - s0, 0);
        check("midrst_idle", bus.busy_out, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
